// File: rtl/audio_pwm_mixer_pkg.sv
// Package slot for the audio PWM mixer slice; sizing is local to each module,
// so nothing is shared here yet.
package audio_pwm_mixer_pkg;
endpackage

// File: rtl/audio_pwm_mixer_pwm_gen.sv
// PWM generator: free-running period counter, duty compare, registered output
// and a start-of-period decode exported to the mixer scan logic.
module pwm_gen
  import audio_pwm_mixer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] duty,
  input  logic                    mute,
  output logic [SAMPLE_WIDTH-1:0] cnt,
  output logic                    pwm_out,
  output logic                    period_start
);

  // Output register makes the pulse trail cnt by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= !mute && (cnt < duty);
    end
  end

  assign period_start = (cnt == '0);

endmodule

// File: rtl/audio_pwm_mixer.sv
// Sequential channel mixer with master attenuation and saturation, feeding a
// PWM generator whose duty is refreshed once per period.
module audio_pwm_mixer
  import audio_pwm_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] ch_in,
  input  logic [NUM_CHANNELS-1:0]              ch_en,
  input  logic [2:0]                           volume,
  input  logic                                 mute,
  output logic                                 pwm_out,
  output logic [SAMPLE_WIDTH-1:0]              level,
  output logic                                 period_start
);

  localparam int PERIOD = 2 ** SAMPLE_WIDTH;
  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(NUM_CHANNELS)
                        + (((NUM_CHANNELS & (NUM_CHANNELS - 1)) == 0) ? 1 : 0);

  logic [SAMPLE_WIDTH-1:0] cnt;
  logic [SAMPLE_WIDTH-1:0] duty;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    scan_vld;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        sample_ext;
  logic [ACC_W-1:0]        mix;

  function automatic logic [SAMPLE_WIDTH-1:0] saturate(input logic [ACC_W-1:0] v);
    if (|v[ACC_W-1:SAMPLE_WIDTH])
      return '1;
    return v[SAMPLE_WIDTH-1:0];
  endfunction

  // Channel k is visited only when cnt == k; a masked channel reads as zero.
  always_comb begin
    sample   = '0;
    scan_vld = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(cnt) == i) begin
        scan_vld = 1'b1;
        if (ch_en[i])
          sample = ch_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  assign sample_ext = {{(ACC_W-SAMPLE_WIDTH){1'b0}}, sample};
  assign mix        = acc >> volume;

  // Scan stage: cnt == 0 reloads acc, clearing the previous period's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (scan_vld) begin
      if (cnt == '0)
        acc <= sample_ext;
      else
        acc <= acc + sample_ext;
    end
  end

  // Latch stage: duty only changes on the last count so a period never mixes levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      duty <= '0;
    else if (int'(cnt) == PERIOD - 1)
      duty <= saturate(mix);
  end

  assign level = duty;

  pwm_gen #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_pwm_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty         (duty),
    .mute         (mute),
    .cnt          (cnt),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_audio_pwm_mixer.sv
// Directed bench for audio_pwm_mixer (W=8, N=4): table of mix vectors plus
// hand-written reset, late-change, mute and asynchronous-reset sequences.
module tb_audio_pwm_mixer;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   ch_in;
  logic [N-1:0]     ch_en;
  logic [2:0]       volume;
  logic             mute;
  logic             pwm_out;
  logic [W-1:0]     level;
  logic             period_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N*W-1:0] ch_in;
    logic [N-1:0]   ch_en;
    logic [2:0]     volume;
    logic [W-1:0]   exp_level;
    int             exp_high;
  } vec_t;

  vec_t vecs[8];

  audio_pwm_mixer #(.NUM_CHANNELS(N), .SAMPLE_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_in        (ch_in),
    .ch_en        (ch_en),
    .volume       (volume),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .level        (level),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Leaves the bench at the negedge where cnt == 0.
  task automatic wait_ps(input string name);
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL %s: period_start not seen within 300 clocks", name);
    end
  endtask

  // Counts pwm_out highs over the 256 samples that reflect the current period.
  task automatic count_high(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out === 1'b1) n++;
    end
  endtask

  task automatic apply_and_settle(input vec_t v, input string name);
    ch_in  = v.ch_in;
    ch_en  = v.ch_en;
    volume = v.volume;
    wait_ps(name);
    @(negedge clk);
    wait_ps(name);
  endtask

  initial begin
    int hi;

    vecs[0] = '{32'h0000_0000, 4'b1111, 3'd0, 8'h00,   0};
    vecs[1] = '{32'h0000_2040, 4'b1111, 3'd0, 8'h60,  96};
    vecs[2] = '{32'hFFFF_FFFF, 4'b1111, 3'd0, 8'hFF, 255};
    vecs[3] = '{32'hFFFF_FFFF, 4'b1111, 3'd2, 8'hFF, 255};
    vecs[4] = '{32'hFFFF_FFFF, 4'b1111, 3'd3, 8'h7F, 127};
    vecs[5] = '{32'h0000_8010, 4'b0001, 3'd0, 8'h10,  16};
    vecs[6] = '{32'h0577_30FF, 4'b1010, 3'd0, 8'h35,  53};
    vecs[7] = '{32'hFFFF_FFFF, 4'b1111, 3'd7, 8'h07,   7};

    rst_n  = 1'b0;
    ch_in  = '0;
    ch_en  = '1;
    volume = 3'd0;
    mute   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_level", int'(level), 0);
    check("reset_period_start", int'(period_start), 1);

    rst_n = 1'b1;
    hi = 0;
    repeat (3 * 256) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
    check("idle_three_periods_high", hi, 0);

    foreach (vecs[i]) begin
      apply_and_settle(vecs[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].exp_level));
      count_high(hi);
      check($sformatf("vec%0d_high", i), hi, vecs[i].exp_high);
    end

    // Late change of ch0 after its scan cycle.
    apply_and_settle(vecs[5], "late_setup");
    check("late_initial_level", int'(level), 8'h10);
    repeat (100) @(negedge clk);
    ch_in[7:0] = 8'h20;
    @(negedge clk);
    wait_ps("late_p1");
    check("late_same_period_level", int'(level), 8'h10);
    @(negedge clk);
    wait_ps("late_p2");
    check("late_next_period_level", int'(level), 8'h20);

    // Mute mid-pulse with level 0x60.
    apply_and_settle(vecs[1], "mute_setup");
    repeat (10) @(negedge clk);
    check("mute_before_pwm", int'(pwm_out), 1);
    mute = 1'b1;
    @(negedge clk);
    check("mute_pwm", int'(pwm_out), 0);
    check("mute_level", int'(level), 8'h60);
    mute = 1'b0;
    @(negedge clk);
    check("unmute_pwm", int'(pwm_out), 1);

    // Asynchronous reset mid-pulse.
    repeat (5) @(negedge clk);
    check("pre_reset_pwm", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_level", int'(level), 0);
    check("async_reset_period_start", int'(period_start), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_period_start", int'(period_start), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_pwm_mixer.md
# audio_pwm_mixer

Audio back end that sits directly downstream of the PCM sample players. It sums up to NUM_CHANNELS unsigned sample streams, applies a master attenuation and saturation, and drives a single-bit PWM output to the speaker pin. Channels are scanned sequentially, one per clock, inside each PWM period. The mixed level is latched once per period, so duty never changes mid-period.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of mixed sample inputs; 1 ≤ NUM_CHANNELS ≤ 2^SAMPLE_WIDTH − 1
- SAMPLE_WIDTH, 8, width of each sample, duty word and PWM counter; PWM period = 2^SAMPLE_WIDTH clocks

Ports:
- clk, input, 1, system clock; one clock domain, all logic on posedge
- rst_n, input, 1, asynchronous active-low reset
- ch_in, input, NUM_CHANNELS*SAMPLE_WIDTH, packed samples; channel i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]; idle players drive 0
- ch_en, input, NUM_CHANNELS, per-channel enable mask; a disabled channel contributes 0
- volume, input, 3, attenuation as a right shift of 0..7 applied to the sum
- mute, input, 1, forces pwm_out low
- pwm_out, output, 1, registered PWM output
- level, output, SAMPLE_WIDTH, duty word in effect for the current period
- period_start, output, 1, high during the cycle where the PWM counter is 0

## Operation
- cnt is a SAMPLE_WIDTH-bit free-running counter: 0 → 2^W−1, then wraps to 0.
- Scan, for cnt = k with k < NUM_CHANNELS:
  - k = 0: acc ← (ch_en[0] ? ch_in[0] : 0). This load clears the previous period's sum.
  - k > 0: acc ← acc + (ch_en[k] ? ch_in[k] : 0).
  - acc width is SAMPLE_WIDTH + $clog2(NUM_CHANNELS), plus 1 when NUM_CHANNELS is a power of 2. The sum never overflows.
- Each channel is sampled only in its own scan cycle. Changes to ch_in or ch_en after that cycle take effect next period.
- Latch, in the cycle where cnt = 2^W−1:
  - mix = acc >> volume, with volume sampled in that cycle.
  - duty ← (mix > 2^W−1) ? 2^W−1 : mix.
- PWM:
  - pwm_out ← !mute && (cnt < duty), registered.
  - pwm_out is high for exactly duty clocks per period, so the maximum is 255/256 for W=8. Duty 0 gives a constant low.
- mute acts on the next clock edge. It does not alter acc or duty, so unmuting resumes at the current level.
- level = duty register; period_start = (cnt == 0), a decode of registers only.

## Timing
- Reset values (asynchronous): cnt 0, acc 0, duty 0, pwm_out 0, level 0. period_start reads 1 while in reset, because cnt = 0.
- After reset release, the first period outputs duty 0.
- First mix latency:
  - The first duty computed from inputs takes effect 2^W clocks after release.
  - pwm_out reflects it one clock later, due to the output register.
- pwm_out lags cnt by one clock: the high pulse starts the cycle after cnt = 0.
- Reset asserted mid-period clears everything immediately, and pwm_out drops low without waiting for a clock. The period restarts at cnt = 0 on release.
- A volume change takes effect only at the next latch.
- A simultaneous ch_in change and scan of that channel uses the pre-edge (registered upstream) value.

## Structure
- No shared package entries. PERIOD = 2^SAMPLE_WIDTH and ACC_W are localparams.
- One sub-module, pwm_gen: counter, compare, registered output and period_start. It takes duty and mute as inputs and exports cnt to the mixer scan logic.
- Scan/accumulate/saturate logic lives in the top module.

## Test plan
All scenarios use W=8, N=4.
- Reset values: hold rst_n low → pwm_out 0, level 0. Release with all channels at 0 → pwm_out stays 0 for 3 full periods.
- Basic mix: ch0=0x40, ch1=0x20, others 0, all enabled, volume 0 → level 0x60 from the second period, and pwm_out high for exactly 96 of every 256 clocks.
- Saturation and shift:
  - All channels 0xFF, volume 0 → sum 0x3FC, level 0xFF, pwm_out high for 255 of 256 clocks.
  - Volume 2 → level 0xFF.
  - Volume 3 → level 0x7F.
- Mask and late change:
  - ch_en=4'b0001 with ch0=0x10, ch1=0x80 → level 0x10.
  - Changing ch0 to 0x20 when cnt=100 → level stays 0x10 this period and becomes 0x20 next period.
- Mute and async reset:
  - Assert mute mid-pulse → pwm_out 0 the next clock, level unchanged; deassert → resumes within the same period.
  - Assert rst_n low mid-period → pwm_out 0 before the next clock edge.
